rvfi_bus_responder: RTL and testbench
=====================================

RVFI_BUS_RESPONDER -- requirements
Module: rvfi_bus_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, request address width.
REQ-002 SHALL have parameter DATA_W, default 32, request/response data width.
REQ-003 SHALL have parameter MAX_OUT, default 4, legal 1..16, max outstanding read responses.
REQ-004 SHALL have parameter MAX_STALL, default 4, legal 2..15, fairness bound in cycles.
REQ-005 SHALL have one clock and an asynchronous, active-high reset, named as follows:
 clock  in  1  sole clock, rising edge.
 reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have the following request ports:
 req_valid  in  1  request valid.
 req_ready  out  1  request accepted this cycle.
 req_wr  in  1  1=write (no response), 0=read.
 req_addr  in  ADDR_W  request address.
 req_size  in  2  0=byte, 1=half, 2=word.
 req_data  in  DATA_W  write data.
REQ-007 SHALL have the following response ports:
 rsp_valid  out  1  read response valid; no backpressure.
 rsp_data  out  DATA_W  response data.
 rsp_addr  out  ADDR_W  address of the read being answered.
REQ-008 SHALL have the following free-variable and status ports:
 rand_req_ready  in  1  free variable from formal/testbench.
 rand_rsp_valid  in  1  free variable.
 rand_rsp_data  in  DATA_W  free variable.
 outstanding  out  5  reads accepted, not yet answered.
 proto_err  out  1  sticky requester protocol violation.

Function
REQ-009 SHALL assert req_ready = req_valid && (rand_req_ready || force_req) && (req_wr || outstanding < MAX_OUT), using the registered count only, with no same-cycle pop bypass.
REQ-010 SHALL push req_addr into an address FIFO of depth MAX_OUT on an accepted read (req_valid && req_ready && !req_wr); accepted writes SHALL NOT push.
REQ-011 SHALL assert rsp_valid = (outstanding > 0) && (rand_rsp_valid || force_rsp), combinationally, with rsp_addr = FIFO head and rsp_data = rand_rsp_data.
REQ-012 SHALL pop the FIFO on rsp_valid; outstanding SHALL update next cycle as outstanding + push - pop, so simultaneous push and pop leave it unchanged.
REQ-013 SHALL use FIFO pointers of width clog2(MAX_OUT)+1 that wrap modulo MAX_OUT; the minimum read-to-response latency is 1 cycle.
REQ-014 SHALL track a stall state STATE_IDLE/STATE_HOLD: IDLE->HOLD when req_valid && !req_ready; HOLD->IDLE on handshake.
REQ-015 SHALL, in HOLD, set proto_err when req_valid deasserts or any of req_wr/req_addr/req_size/req_data differs from the value captured at HOLD entry.
REQ-016 SHALL set proto_err when req_size==3 with req_valid; proto_err SHALL clear only on reset.
REQ-017 SHALL keep force_req = force_rsp = 0 whenever REQ_FAIRNESS_EN is undefined.

Reset
REQ-018 SHALL drive, while reset is high: outstanding=0, FIFO empty, state IDLE, proto_err=0, stall counters 0, req_ready=0, rsp_valid=0.
REQ-019 SHALL discard all in-flight reads on reset assertion mid-operation, with no response issued for them.

Configuration
REQ-020 SHALL, when REQ_FAIRNESS_EN is defined, keep req_stall (4b), incremented while req_valid && !req_ready and cleared otherwise, and set force_req when req_stall == MAX_STALL-1.
REQ-021 SHALL, when REQ_FAIRNESS_EN is defined, keep rsp_stall (4b), incremented while outstanding>0 && !rsp_valid and cleared on rsp_valid or when empty, and set force_rsp when rsp_stall == MAX_STALL-1.
REQ-022 SHALL, when REQ_FAIRNESS_EN is defined, let every stall be at most MAX_STALL cycles except a request blocked only by full capacity, which waits until a response pops; when undefined, stalls SHALL be unbounded and the counters SHALL not exist.

Verification
REQ-023 SHALL cover: read addr 0x100, rand_req_ready=1 -> req_ready same cycle; outstanding=1 next cycle; rand_rsp_valid=1 -> rsp_valid with rsp_addr=0x100; outstanding=0.
REQ-024 SHALL cover: MAX_OUT=4, five back-to-back reads, rand_rsp_valid=0 -> reads 1-4 accepted; 5th req_ready=0 while outstanding=4; one response -> 5th accepted the cycle after the pop.
REQ-025 SHALL cover: write with rand_req_ready=1 -> accepted, outstanding stays 0, rsp_valid never asserts.
REQ-026 SHALL cover: REQ_FAIRNESS_EN, MAX_STALL=4, rand_req_ready=0 held, read pending -> req_ready asserts in the 4th stall cycle; with rand_rsp_valid=0, rsp_valid asserts 4 cycles after outstanding>0.
REQ-027 SHALL cover: stalled read with req_addr changed 0x100->0x104 -> proto_err=1 next cycle and held until reset.
REQ-028 SHALL cover: reset asserted with outstanding=3, FIFO wrapped -> outstanding=0, rsp_valid=0 asynchronously; the next read after release is answered with its own address.

Source files
------------

// File: rtl/rvfi_bus_responder_if.sv
// Request/response bus between a requester (or formal harness) and rvfi_bus_responder.
// The rand_* lines are free variables that steer the responder's ready/valid choices.
interface rvfi_bus_responder_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_wr;
    logic [ADDR_W-1:0] req_addr;
    logic [1:0]        req_size;
    logic [DATA_W-1:0] req_data;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic [ADDR_W-1:0] rsp_addr;
    logic              rand_req_ready;
    logic              rand_rsp_valid;
    logic [DATA_W-1:0] rand_rsp_data;
    logic [4:0]        outstanding;
    logic              proto_err;

    modport master (
        output req_valid, req_wr, req_addr, req_size, req_data,
        output rand_req_ready, rand_rsp_valid, rand_rsp_data,
        input  req_ready, rsp_valid, rsp_data, rsp_addr, outstanding, proto_err
    );

    modport slave (
        input  req_valid, req_wr, req_addr, req_size, req_data,
        input  rand_req_ready, rand_rsp_valid, rand_rsp_data,
        output req_ready, rsp_valid, rsp_data, rsp_addr, outstanding, proto_err
    );
endinterface

// File: rtl/rvfi_bus_responder.sv
// Nondeterministic bus responder: accepts requests, answers reads in order, flags requester
// protocol violations. Define REQ_FAIRNESS_EN to bound request/response stalls to MAX_STALL.
module rvfi_bus_responder #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MAX_OUT   = 4,
    parameter int unsigned MAX_STALL = 4
) (
    input logic              clock,
    input logic              reset,
    rvfi_bus_responder_if.slave bus
);
    localparam int unsigned      PTR_W    = $clog2(MAX_OUT) + 1;
    localparam int unsigned      IDX_W    = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam logic [4:0]       OUT_MAX  = 5'(MAX_OUT);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUT - 1);

    typedef enum logic [0:0] {StateIdle, StateHold} state_e;

    logic [ADDR_W-1:0] fifo_q [MAX_OUT];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [4:0]        outstanding_q, outstanding_d;
    state_e            state_q, state_d;
    logic              proto_err_q, proto_err_d;
    logic              capture;
    logic              hold_wr_q;
    logic [ADDR_W-1:0] hold_addr_q;
    logic [1:0]        hold_size_q;
    logic [DATA_W-1:0] hold_data_q;
    logic              force_req, force_rsp;
    logic              req_ready, rsp_valid, push, pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // Gated by reset so both handshake outputs read low while reset is held.
    always_comb begin
        req_ready = !reset && bus.req_valid && (bus.rand_req_ready || force_req)
                    && (bus.req_wr || (outstanding_q < OUT_MAX));
        rsp_valid = !reset && (outstanding_q != 5'd0) && (bus.rand_rsp_valid || force_rsp);
        push      = req_ready && !bus.req_wr;
        pop       = rsp_valid;
    end

    assign bus.req_ready   = req_ready;
    assign bus.rsp_valid   = rsp_valid;
    assign bus.rsp_data    = bus.rand_rsp_data;
    assign bus.rsp_addr    = fifo_q[rd_ptr_q[IDX_W-1:0]];
    assign bus.outstanding = outstanding_q;
    assign bus.proto_err   = proto_err_q;

    always_comb begin
        outstanding_d = outstanding_q;
        unique case ({push, pop})
            2'b10:   outstanding_d = outstanding_q + 5'd1;
            2'b01:   outstanding_d = outstanding_q - 5'd1;
            default: outstanding_d = outstanding_q;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        proto_err_d = proto_err_q;
        capture     = 1'b0;
        unique case (state_q)
            StateIdle: begin
                if (bus.req_valid && !req_ready) begin
                    state_d = StateHold;
                    capture = 1'b1;
                end
            end
            StateHold: begin
                // A stalled request must stay valid and stable until it is taken.
                if (!bus.req_valid || (bus.req_wr != hold_wr_q) || (bus.req_addr != hold_addr_q)
                    || (bus.req_size != hold_size_q) || (bus.req_data != hold_data_q)) begin
                    proto_err_d = 1'b1;
                end
                if (bus.req_valid && req_ready) state_d = StateIdle;
            end
            default: state_d = StateIdle;
        endcase
        if (bus.req_valid && (bus.req_size == 2'd3)) proto_err_d = 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            outstanding_q <= '0;
            state_q       <= StateIdle;
            proto_err_q   <= 1'b0;
            hold_wr_q     <= 1'b0;
            hold_addr_q   <= '0;
            hold_size_q   <= '0;
            hold_data_q   <= '0;
        end else begin
            if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            outstanding_q <= outstanding_d;
            state_q       <= state_d;
            proto_err_q   <= proto_err_d;
            if (capture) begin
                hold_wr_q   <= bus.req_wr;
                hold_addr_q <= bus.req_addr;
                hold_size_q <= bus.req_size;
                hold_data_q <= bus.req_data;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push) fifo_q[wr_ptr_q[IDX_W-1:0]] <= bus.req_addr;
    end

`ifdef REQ_FAIRNESS_EN
    localparam logic [3:0] STALL_LAST = 4'(MAX_STALL - 1);

    logic [3:0] req_stall_q, rsp_stall_q;

    assign force_req = (req_stall_q == STALL_LAST);
    assign force_rsp = (rsp_stall_q == STALL_LAST);

    // Counters saturate so a capacity-blocked request is taken as soon as a slot frees.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            req_stall_q <= '0;
            rsp_stall_q <= '0;
        end else begin
            if (bus.req_valid && !req_ready) begin
                req_stall_q <= force_req ? req_stall_q : req_stall_q + 4'd1;
            end else begin
                req_stall_q <= '0;
            end
            if ((outstanding_q != 5'd0) && !rsp_valid) begin
                rsp_stall_q <= force_rsp ? rsp_stall_q : rsp_stall_q + 4'd1;
            end else begin
                rsp_stall_q <= '0;
            end
        end
    end
`else
    assign force_req = 1'b0;
    assign force_rsp = 1'b0;
`endif
endmodule

// File: tb/tb_rvfi_bus_responder.sv
// Self-checking bench for rvfi_bus_responder: directed scenarios plus a randomized run
// checked against a queue-based model of the responder's rules.
module tb_rvfi_bus_responder;
    localparam int unsigned MAX_OUT   = 4;
    localparam int unsigned MAX_STALL = 4;
`ifdef REQ_FAIRNESS_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clock = ~clock;

    rvfi_bus_responder_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    rvfi_bus_responder #(
        .ADDR_W(32), .DATA_W(32), .MAX_OUT(MAX_OUT), .MAX_STALL(MAX_STALL)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    task automatic idle_inputs;
        bus.req_valid      = 1'b0;
        bus.req_wr         = 1'b0;
        bus.req_addr       = '0;
        bus.req_size       = 2'd2;
        bus.req_data       = '0;
        bus.rand_req_ready = 1'b0;
        bus.rand_rsp_valid = 1'b0;
        bus.rand_rsp_data  = '0;
    endtask

    task automatic do_reset;
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
    endtask

    task automatic next_cycle;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset;
        idle_inputs();
        reset = 1'b1;
        bus.req_valid = 1'b1;
        bus.rand_req_ready = 1'b1;
        bus.rand_rsp_valid = 1'b1;
        @(negedge clock);
        n_cmp++; if (bus.req_ready !== 1'b0) begin n_bad++; $display("FAIL rst_req_ready: got %b want 0", bus.req_ready); end
        n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_rsp_valid: got %b want 0", bus.rsp_valid); end
        n_cmp++; if (bus.outstanding !== 5'd0) begin n_bad++; $display("FAIL rst_outstanding: got %0d want 0", bus.outstanding); end
        n_cmp++; if (bus.proto_err !== 1'b0) begin n_bad++; $display("FAIL rst_proto_err: got %b want 0", bus.proto_err); end
        do_reset();
    endtask

    task automatic test_single_read;
        do_reset();
        bus.req_valid = 1'b1; bus.req_wr = 1'b0; bus.req_addr = 32'h100; bus.rand_req_ready = 1'b1;
        @(negedge clock);
        n_cmp++; if (bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL rd_req_ready: got %b want 1", bus.req_ready); end
        next_cycle();
        bus.req_valid = 1'b0; bus.rand_rsp_valid = 1'b1; bus.rand_rsp_data = 32'hDEAD_BEEF;
        @(negedge clock);
        n_cmp++; if (bus.outstanding !== 5'd1) begin n_bad++; $display("FAIL rd_outstanding: got %0d want 1", bus.outstanding); end
        n_cmp++; if (bus.rsp_valid !== 1'b1) begin n_bad++; $display("FAIL rd_rsp_valid: got %b want 1", bus.rsp_valid); end
        n_cmp++; if (bus.rsp_addr !== 32'h100) begin n_bad++; $display("FAIL rd_rsp_addr: got %h want 100", bus.rsp_addr); end
        n_cmp++; if (bus.rsp_data !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL rd_rsp_data: got %h want deadbeef", bus.rsp_data); end
        next_cycle();
        @(negedge clock);
        n_cmp++; if (bus.outstanding !== 5'd0) begin n_bad++; $display("FAIL rd_drained: got %0d want 0", bus.outstanding); end
        n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rd_rsp_idle: got %b want 0", bus.rsp_valid); end
    endtask

    task automatic test_write;
        int bad_rsp = 0;
        do_reset();
        bus.req_valid = 1'b1; bus.req_wr = 1'b1; bus.req_addr = 32'h200; bus.req_data = 32'h55AA;
        bus.rand_req_ready = 1'b1; bus.rand_rsp_valid = 1'b1;
        @(negedge clock);
        n_cmp++; if (bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL wr_req_ready: got %b want 1", bus.req_ready); end
        next_cycle();
        bus.req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            if (bus.rsp_valid !== 1'b0 || bus.outstanding !== 5'd0) bad_rsp++;
            next_cycle();
        end
        n_cmp++; if (bad_rsp != 0) begin n_bad++; $display("FAIL wr_no_rsp: got %0d bad cycles want 0", bad_rsp); end
    endtask

    task automatic test_back_to_back;
        do_reset();
        bus.rand_req_ready = 1'b1; bus.req_valid = 1'b1; bus.req_wr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.req_addr = 32'h1000 + 32'(4 * i);
            @(negedge clock);
            n_cmp++; if (bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_accept%0d: got %b want 1", i, bus.req_ready); end
            next_cycle();
        end
        bus.req_addr = 32'h1010;
        @(negedge clock);
        n_cmp++; if (bus.req_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_full_ready: got %b want 0", bus.req_ready); end
        n_cmp++; if (bus.outstanding !== 5'd4) begin n_bad++; $display("FAIL b2b_full_cnt: got %0d want 4", bus.outstanding); end
        next_cycle();
        bus.rand_rsp_valid = 1'b1;
        @(negedge clock);
        n_cmp++; if (bus.rsp_addr !== 32'h1000) begin n_bad++; $display("FAIL b2b_rsp_addr: got %h want 1000", bus.rsp_addr); end
        n_cmp++; if (bus.req_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_no_bypass: got %b want 0", bus.req_ready); end
        next_cycle();
        bus.rand_rsp_valid = 1'b0;
        @(negedge clock);
        n_cmp++; if (bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_after_pop: got %b want 1", bus.req_ready); end
        next_cycle();
        bus.req_valid = 1'b0;
        @(negedge clock);
        n_cmp++; if (bus.outstanding !== 5'd4) begin n_bad++; $display("FAIL b2b_refill: got %0d want 4", bus.outstanding); end
    endtask

    task automatic test_proto_err;
        do_reset();
        bus.req_valid = 1'b1; bus.req_addr = 32'h100;
        @(negedge clock);
        n_cmp++; if (bus.req_ready !== 1'b0) begin n_bad++; $display("FAIL pe_stall: got %b want 0", bus.req_ready); end
        next_cycle();
        bus.req_addr = 32'h104;
        @(negedge clock);
        n_cmp++; if (bus.proto_err !== 1'b0) begin n_bad++; $display("FAIL pe_early: got %b want 0", bus.proto_err); end
        next_cycle();
        idle_inputs();
        repeat (3) next_cycle();
        @(negedge clock);
        n_cmp++; if (bus.proto_err !== 1'b1) begin n_bad++; $display("FAIL pe_sticky: got %b want 1", bus.proto_err); end
        do_reset();
        @(negedge clock);
        n_cmp++; if (bus.proto_err !== 1'b0) begin n_bad++; $display("FAIL pe_cleared: got %b want 0", bus.proto_err); end
        next_cycle();
        bus.req_valid = 1'b1; bus.req_wr = 1'b1; bus.req_size = 2'd3; bus.rand_req_ready = 1'b1;
        next_cycle();
        idle_inputs();
        @(negedge clock);
        n_cmp++; if (bus.proto_err !== 1'b1) begin n_bad++; $display("FAIL pe_size3: got %b want 1", bus.proto_err); end
    endtask

    task automatic test_reset_mid;
        do_reset();
        bus.rand_req_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.req_valid = 1'b1; bus.req_addr = 32'h40 + 32'(i);
            next_cycle();
            bus.req_valid = 1'b0; bus.rand_rsp_valid = 1'b1;
            next_cycle();
            bus.rand_rsp_valid = 1'b0;
        end
        bus.req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.req_addr = 32'h80 + 32'(i);
            next_cycle();
        end
        bus.req_valid = 1'b0;
        @(negedge clock);
        n_cmp++; if (bus.outstanding !== 5'd3) begin n_bad++; $display("FAIL mid_pre_cnt: got %0d want 3", bus.outstanding); end
        next_cycle();
        bus.rand_rsp_valid = 1'b1;
        #2 reset = 1'b1;
        #1;
        n_cmp++; if (bus.outstanding !== 5'd0) begin n_bad++; $display("FAIL mid_async_cnt: got %0d want 0", bus.outstanding); end
        n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL mid_async_rsp: got %b want 0", bus.rsp_valid); end
        bus.rand_rsp_valid = 1'b0;
        next_cycle();
        reset = 1'b0;
        bus.req_valid = 1'b1; bus.req_addr = 32'h2A0;
        next_cycle();
        bus.req_valid = 1'b0; bus.rand_rsp_valid = 1'b1;
        @(negedge clock);
        n_cmp++; if (bus.rsp_valid !== 1'b1) begin n_bad++; $display("FAIL mid_post_valid: got %b want 1", bus.rsp_valid); end
        n_cmp++; if (bus.rsp_addr !== 32'h2A0) begin n_bad++; $display("FAIL mid_post_addr: got %h want 2a0", bus.rsp_addr); end
        next_cycle();
    endtask

    task automatic test_fairness;
        do_reset();
        bus.req_valid = 1'b1; bus.req_addr = 32'h300;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            n_cmp++; if (bus.req_ready !== (k == 3)) begin n_bad++; $display("FAIL fair_req%0d: got %b want %b", k, bus.req_ready, k == 3); end
            next_cycle();
        end
        bus.req_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            n_cmp++; if (bus.rsp_valid !== (k == 3)) begin n_bad++; $display("FAIL fair_rsp%0d: got %b want %b", k, bus.rsp_valid, k == 3); end
            next_cycle();
        end
    endtask

    task automatic test_random;
        logic [31:0] mq[$];
        int req_wait = 0;
        int rsp_wait = 0;
        bit stalled = 1'b0;
        bit e_ready, e_rsp, fr, frs;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            if (!stalled) begin
                bus.req_valid = ($urandom_range(0, 3) != 0);
                bus.req_wr    = ($urandom_range(0, 3) == 0);
                bus.req_addr  = $urandom;
                bus.req_size  = 2'($urandom_range(0, 2));
                bus.req_data  = $urandom;
            end
            bus.rand_req_ready = ($urandom_range(0, 1) == 1);
            bus.rand_rsp_valid = ($urandom_range(0, 2) == 0);
            bus.rand_rsp_data  = $urandom;
            fr     = FAIR && (req_wait >= int'(MAX_STALL) - 1);
            frs    = FAIR && (rsp_wait >= int'(MAX_STALL) - 1);
            e_ready = bus.req_valid && (bus.rand_req_ready || fr)
                      && (bus.req_wr || mq.size() < int'(MAX_OUT));
            e_rsp   = (mq.size() > 0) && (bus.rand_rsp_valid || frs);
            @(negedge clock);
            n_cmp++; if (bus.req_ready !== e_ready) begin n_bad++; $display("FAIL rnd_req_ready@%0d: got %b want %b", c, bus.req_ready, e_ready); end
            n_cmp++; if (bus.rsp_valid !== e_rsp) begin n_bad++; $display("FAIL rnd_rsp_valid@%0d: got %b want %b", c, bus.rsp_valid, e_rsp); end
            n_cmp++; if (bus.outstanding !== 5'(mq.size())) begin n_bad++; $display("FAIL rnd_outstanding@%0d: got %0d want %0d", c, bus.outstanding, mq.size()); end
            n_cmp++; if (bus.proto_err !== 1'b0) begin n_bad++; $display("FAIL rnd_proto_err@%0d: got %b want 0", c, bus.proto_err); end
            if (e_rsp) begin
                n_cmp++; if (bus.rsp_addr !== mq[0]) begin n_bad++; $display("FAIL rnd_rsp_addr@%0d: got %h want %h", c, bus.rsp_addr, mq[0]); end
                n_cmp++; if (bus.rsp_data !== bus.rand_rsp_data) begin n_bad++; $display("FAIL rnd_rsp_data@%0d: got %h want %h", c, bus.rsp_data, bus.rand_rsp_data); end
            end
            @(posedge clock);
            req_wait = (bus.req_valid && !e_ready) ? req_wait + 1 : 0;
            rsp_wait = (mq.size() > 0 && !e_rsp) ? rsp_wait + 1 : 0;
            if (e_rsp) void'(mq.pop_front());
            if (e_ready && !bus.req_wr) mq.push_back(bus.req_addr);
            stalled = bus.req_valid && !e_ready;
            #1;
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single_read();
        test_write();
`ifndef REQ_FAIRNESS_EN
        test_back_to_back();
`else
        test_fairness();
`endif
        test_proto_err();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
